// File: rtl/compact_buffer_pkg.sv
// Shared helpers for the compacting buffer: lane population count used by
// the compactor to rank sparse input lanes.
package compact_buffer_pkg;

    // Widest lane bitmap the helper accepts; callers zero-extend into it.
    localparam int MAX_LANES  = 32;
    localparam int LANE_CNT_W = $clog2(MAX_LANES + 1);

    // Number of set bits in a lane bitmap.
    function automatic logic [LANE_CNT_W-1:0] count_one(input logic [MAX_LANES-1:0] v);
        logic [LANE_CNT_W-1:0] n;
        n = '0;
        for (int i = 0; i < MAX_LANES; i++) begin
            n = n + LANE_CNT_W'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/compact_buffer_if.sv
// Producer/consumer bundle of the compacting buffer. The master side is the
// block driving sparse enqueues and dense dequeue counts; the slave side is
// the buffer itself.
interface compact_buffer_if #(
    parameter type dtype       = logic,
    parameter int  INPORT_NUM  = 4,
    parameter int  OUTPORT_NUM = 4,
    parameter int  DEPTH       = 8
);

    logic                               i_flush;
    logic [INPORT_NUM-1:0]              i_enq_vld;
    dtype                               i_enq_datas [INPORT_NUM];
    logic                               o_can_enq;
    logic [OUTPORT_NUM-1:0]             o_deq_vld;
    dtype                               o_deq_datas [OUTPORT_NUM];
    logic [$clog2(OUTPORT_NUM+1)-1:0]   i_deq_num;
    logic [$clog2(DEPTH+1)-1:0]         o_count;

    modport master (
        output i_flush,
        output i_enq_vld,
        output i_enq_datas,
        output i_deq_num,
        input  o_can_enq,
        input  o_deq_vld,
        input  o_deq_datas,
        input  o_count
    );

    modport slave (
        input  i_flush,
        input  i_enq_vld,
        input  i_enq_datas,
        input  i_deq_num,
        output o_can_enq,
        output o_deq_vld,
        output o_deq_datas,
        output o_count
    );

endinterface

// File: rtl/compact_buffer_compactor.sv
// Combinational gather: ranks every valid input lane by the number of valid
// lanes below it, totals the valid lanes, and packs the valid payloads into
// a dense, lane-ordered prefix.
module compact_buffer_compactor
    import compact_buffer_pkg::*;
#(
    parameter type dtype      = logic,
    parameter int  INPORT_NUM = 4
) (
    input  logic [INPORT_NUM-1:0]             i_vld,
    input  dtype                              i_datas [INPORT_NUM],
    output logic [$clog2(INPORT_NUM+1)-1:0]   o_rank  [INPORT_NUM],
    output logic [$clog2(INPORT_NUM+1)-1:0]   o_total,
    output dtype                              o_dense [INPORT_NUM]
);

    localparam int CNT_W = $clog2(INPORT_NUM + 1);

    logic [MAX_LANES-1:0] vld_ext;

    // Rank each lane, then route lane k to dense slot rank[k].
    always_comb begin
        vld_ext = '0;
        vld_ext[INPORT_NUM-1:0] = i_vld;
        for (int k = 0; k < INPORT_NUM; k++) begin
            o_rank[k] = CNT_W'(count_one(vld_ext & ((MAX_LANES'(1) << k) - MAX_LANES'(1))));
        end
        o_total = CNT_W'(count_one(vld_ext));
        for (int r = 0; r < INPORT_NUM; r++) begin
            o_dense[r] = '0;
            for (int k = 0; k < INPORT_NUM; k++) begin
                if (i_vld[k] && (o_rank[k] == CNT_W'(r))) begin
                    o_dense[r] = i_datas[k];
                end
            end
        end
    end

endmodule

// File: rtl/compact_buffer.sv
// Compacting (gather) queue. Sparse lane-valid writes are stored densely in
// lane order; the oldest entries are presented as a dense prefix of up to
// OUTPORT_NUM lanes. Occupancy, not pointer equality, decides full/empty.
//
// Build options:
//   COMPACT_BUFFER_BYPASS_EN  - when empty, present the compacted input in
//                               the same cycle; consumed entries are not
//                               stored.
//   COMPACT_BUFFER_ASSERT_ON  - flag enqueues attempted while o_can_enq=0.
module compact_buffer
    import compact_buffer_pkg::*;
#(
    parameter type dtype       = logic,
    parameter int  INPORT_NUM  = 4,
    parameter int  OUTPORT_NUM = 4,
    parameter int  DEPTH       = 8
) (
    input logic               clk,
    input logic               rst,
    compact_buffer_if.slave   bus
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int IN_W  = $clog2(INPORT_NUM + 1);
    localparam int MAXP  = (INPORT_NUM > OUTPORT_NUM) ? INPORT_NUM : OUTPORT_NUM;

    logic [PTR_W-1:0]       head;
    logic [PTR_W-1:0]       tail;
    logic [CNT_W-1:0]       count;
    dtype                   mem [DEPTH];

    logic                   can_enq;
    logic                   bypass_sel;
    logic [INPORT_NUM-1:0]  enq_acc;
    logic [IN_W-1:0]        rank [INPORT_NUM];
    logic [IN_W-1:0]        enq_total;
    dtype                   dense [INPORT_NUM];
    dtype                   dense_ext [MAXP];

    int                     avail_n;
    int                     deq_n;
    int                     skip_n;

    // A full-width write is accepted only if every lane could be valid.
    assign can_enq = (int'(count) <= (DEPTH - INPORT_NUM));
    assign enq_acc = can_enq ? bus.i_enq_vld : '0;

`ifdef COMPACT_BUFFER_BYPASS_EN
    assign bypass_sel = (count == '0) && can_enq;
`else
    assign bypass_sel = 1'b0;
`endif

    compact_buffer_compactor #(
        .dtype      (dtype),
        .INPORT_NUM (INPORT_NUM)
    ) u_compactor (
        .i_vld      (enq_acc),
        .i_datas    (bus.i_enq_datas),
        .o_rank     (rank),
        .o_total    (enq_total),
        .o_dense    (dense)
    );

    // Pad the dense input to the output width so lane selection stays in range.
    for (genvar r = 0; r < MAXP; r++) begin : g_dense_ext
        if (r < INPORT_NUM) begin : g_in
            assign dense_ext[r] = dense[r];
        end else begin : g_pad
            assign dense_ext[r] = '0;
        end
    end

    // Presentation window, clamped dequeue and number of bypassed entries.
    always_comb begin
        avail_n = bypass_sel ? int'(enq_total) : int'(count);
        if (avail_n > OUTPORT_NUM) begin
            avail_n = OUTPORT_NUM;
        end
        deq_n = int'(bus.i_deq_num);
        if (deq_n > avail_n) begin
            deq_n = avail_n;
        end
        skip_n = bypass_sel ? deq_n : 0;
    end

    // Dense output prefix: oldest entry in lane 0, invalid lanes held at zero.
    always_comb begin
        bus.o_deq_vld = '0;
        for (int j = 0; j < OUTPORT_NUM; j++) begin
            bus.o_deq_datas[j] = '0;
            if (j < avail_n) begin
                bus.o_deq_vld[j] = 1'b1;
                if (bypass_sel) begin
                    bus.o_deq_datas[j] = dense_ext[j];
                end else begin
                    bus.o_deq_datas[j] = mem[PTR_W'(int'(head) + j)];
                end
            end
        end
    end

    assign bus.o_can_enq = can_enq;
    assign bus.o_count   = count;

    // Pointer and occupancy update; flush wins over enqueue and dequeue.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (bus.i_flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= PTR_W'(int'(head) + deq_n - skip_n);
            tail  <= PTR_W'(int'(tail) + int'(enq_total) - skip_n);
            count <= CNT_W'(int'(count) + int'(enq_total) - deq_n);
        end
    end

    // Scatter each accepted lane to tail + rank; bypass-consumed lanes are skipped.
    always_ff @(posedge clk) begin
        if (!bus.i_flush) begin
            for (int k = 0; k < INPORT_NUM; k++) begin
                if (enq_acc[k] && (int'(rank[k]) >= skip_n)) begin
                    mem[PTR_W'(int'(tail) + int'(rank[k]) - skip_n)] <= bus.i_enq_datas[k];
                end
            end
        end
    end

`ifdef COMPACT_BUFFER_ASSERT_ON
    // A producer writing while the buffer cannot take a full write loses data.
    always_ff @(posedge clk) begin
        if (rst && !bus.i_flush) begin
            assert (can_enq || (bus.i_enq_vld == '0));
        end
    end
`endif

endmodule
